// File: rtl/blinker_ctrl_pkg.sv
// blinker_ctrl_pkg: shared types and constants for the blinker rate scheduler
package blinker_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, GRANT, SHIFT, SETTLE, RESP} state_t;
  localparam logic DIR_SLOWER = 1'b1;
  localparam logic DIR_FASTER = 1'b0;
endpackage

// File: rtl/blinker_rate_scheduler_rr_arbiter.sv
// rr_arbiter: picks the first set request at or after ptr, wrapping around
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [$clog2(NREQ)-1:0] grant,
  output logic                    any
);
  localparam int IW = $clog2(NREQ);
  always_comb begin
    grant = '0;
    any = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (!any && req[(int'(ptr) + i) % NREQ]) begin
        grant = IW'((int'(ptr) + i) % NREQ);
        any = 1'b1;
      end
  end
endmodule

// File: rtl/blinker_rate_scheduler.sv
// blinker_rate_scheduler: round-robin arbitration of blink-rate change requests onto one shifter
module blinker_rate_scheduler
  import blinker_ctrl_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int SETTLE_CYC = 2,
  parameter int MAX_POS    = 7,
  parameter int INIT_POS   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         run_en,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ-1:0]              req_dir,
  output logic [NREQ-1:0]              req_ready,
  output logic                         resp_valid,
  output logic [$clog2(NREQ)-1:0]      resp_id,
  output logic                         resp_err,
  output logic                         shift_left,
  output logic                         shift_right,
  output logic                         count_en,
  output logic [$clog2(MAX_POS+1)-1:0] pos
);
  localparam int IW = $clog2(NREQ);
  localparam int PW = $clog2(MAX_POS + 1);
  localparam int CW = $clog2(SETTLE_CYC + 1);
  state_t state, nxt;
  logic [IW-1:0] ptr, g, win;
  logic [CW-1:0] cnt;
  logic any, slower, refuse;
  rr_arbiter #(.NREQ(NREQ)) u_arb (.req(req_valid), .ptr(ptr), .grant(win), .any(any));
  assign slower = req_dir[g] == DIR_SLOWER;
  assign refuse = slower ? (pos == PW'(MAX_POS)) : (pos == '0);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = any ? GRANT : IDLE;
      GRANT:   nxt = refuse ? RESP : SHIFT;
      SHIFT:   nxt = SETTLE;
      SETTLE:  nxt = (cnt == CW'(SETTLE_CYC - 1)) ? RESP : SETTLE;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with the state they belong to
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= '0;
      g           <= '0;
      cnt         <= '0;
      req_ready   <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_err    <= 1'b0;
      shift_left  <= 1'b0;
      shift_right <= 1'b0;
      count_en    <= 1'b0;
      pos         <= PW'(INIT_POS);
    end else begin
      state       <= nxt;
      cnt         <= (state == SETTLE) ? cnt + 1'b1 : '0;
      req_ready   <= '0;
      if (state == IDLE && any) begin
        g              <= win;
        req_ready[win] <= 1'b1;
      end
      if (state == GRANT) ptr <= (g == IW'(NREQ - 1)) ? '0 : g + 1'b1;
      if (state == GRANT && !refuse) pos <= slower ? pos + 1'b1 : pos - 1'b1;
      shift_left  <= state == GRANT && !refuse && slower;
      shift_right <= state == GRANT && !refuse && !slower;
      resp_valid  <= nxt == RESP;
      if (nxt == RESP) begin
        resp_id  <= g;
        resp_err <= state == GRANT;
      end
      count_en    <= nxt == IDLE && run_en;
    end
  end
endmodule

// File: tb/tb_blinker_rate_scheduler.sv
// tb_blinker_rate_scheduler: directed vector table plus hand sequences for arbitration and reset
module tb_blinker_rate_scheduler;
  localparam int SETTLE = 2;
  typedef struct {int id; bit dir; bit err; int pos;} vec_t;
  logic clk = 1'b0, rst = 1'b0, run_en = 1'b1;
  logic [3:0] req_valid = '0, req_dir = '0, req_ready;
  logic resp_valid, resp_err, shift_left, shift_right, count_en;
  logic [1:0] resp_id;
  logic [2:0] pos;
  logic [3:0] pend = '0;
  int n_cmp = 0, n_bad = 0;
  vec_t tv[12];
  blinker_rate_scheduler #(.NREQ(4), .SETTLE_CYC(SETTLE), .MAX_POS(7), .INIT_POS(0)) dut (
    .clk(clk), .rst(rst), .run_en(run_en), .req_valid(req_valid), .req_dir(req_dir),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id), .resp_err(resp_err),
    .shift_left(shift_left), .shift_right(shift_right), .count_en(count_en), .pos(pos));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rst && |(pend & ~req_valid)) $error("FAIL protocol: req_valid %b dropped before req_ready", req_valid);
    pend <= req_valid & ~req_ready;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic serve(input vec_t v);
    req_valid[v.id] = 1'b1;
    req_dir[v.id] = v.dir;
    tick();
    chk("ready", req_ready, 32'(1) << v.id);
    chk("cen_grant", count_en, 0);
    tick();
    req_valid[v.id] = 1'b0;
    if (v.err) begin
      chk("no_pulse", {shift_left, shift_right}, 0);
      chk("resp_valid_err", resp_valid, 1);
      chk("resp_err", resp_err, 1);
      chk("resp_id", resp_id, v.id);
    end else begin
      chk("shift_left", shift_left, v.dir);
      chk("shift_right", shift_right, !v.dir);
      chk("cen_shift", count_en, 0);
      for (int k = 3; k <= 2 + SETTLE; k++) begin
        tick();
        chk("cen_settle", count_en, 0);
        chk("pulse_settle", {shift_left, shift_right}, 0);
      end
      tick();
      chk("resp_valid", resp_valid, 1);
      chk("resp_err_ok", resp_err, 0);
      chk("resp_id", resp_id, v.id);
    end
    chk("pos", pos, v.pos);
    tick();
    chk("resp_gap", resp_valid, 0);
    chk("ready_gap", req_ready, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    int order[4], rid[4];
    int n, rc, drop;
    bit saw;
    tv[0]  = '{0, 1, 0, 1};
    tv[1]  = '{1, 0, 0, 0};
    tv[2]  = '{2, 0, 1, 0};
    tv[3]  = '{0, 1, 0, 1};
    tv[4]  = '{1, 1, 0, 2};
    tv[5]  = '{2, 1, 0, 3};
    tv[6]  = '{3, 1, 0, 4};
    tv[7]  = '{0, 1, 0, 5};
    tv[8]  = '{1, 1, 0, 6};
    tv[9]  = '{2, 1, 0, 7};
    tv[10] = '{3, 1, 1, 7};
    tv[11] = '{3, 0, 0, 6};
    tick();
    tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_resp", {resp_valid, resp_err, resp_id}, 0);
    chk("rst_pulse", {shift_left, shift_right}, 0);
    chk("rst_cen", count_en, 0);
    chk("rst_pos", pos, 0);
    rst = 1'b1;
    tick();
    chk("cen_follow", count_en, 1);
    chk("idle_pulse", {shift_left, shift_right}, 0);
    tick();
    chk("cen_hold", count_en, 1);
    serve(tv[0]);
    req_dir = 4'b0011;
    req_valid = 4'b1110;
    n = 0;
    rc = 0;
    drop = -1;
    for (int c = 0; c < 60 && rc < 4; c++) begin
      tick();
      if (drop >= 0) begin
        req_valid[drop] = 1'b0;
        drop = -1;
      end
      if (req_ready != 0) begin
        chk("onehot", $countones(req_ready), 1);
        for (int i = 0; i < 4; i++) if (req_ready[i] && n < 4) order[n] = i;
        drop = order[n];
        n++;
        if (n == 1) req_valid[0] = 1'b1;
      end
      if (resp_valid) begin
        chk("rr_err", resp_err, 0);
        if (rc < 4) rid[rc] = int'(resp_id);
        rc++;
      end
    end
    chk("rr_grants", n, 4);
    chk("rr_resps", rc, 4);
    chk("rr_order", {order[0][1:0], order[1][1:0], order[2][1:0], order[3][1:0]}, 8'b01_10_11_00);
    chk("rr_ids", {rid[0][1:0], rid[1][1:0], rid[2][1:0], rid[3][1:0]}, 8'b01_10_11_00);
    chk("rr_pos", pos, 1);
    tick();
    for (int i = 1; i < 12; i++) serve(tv[i]);
    req_valid[0] = 1'b1;
    req_dir[0] = 1'b1;
    tick();
    tick();
    req_valid[0] = 1'b0;
    chk("pre_rst_shift", shift_left, 1);
    chk("pre_rst_pos", pos, 7);
    tick();
    rst = 1'b0;
    #1;
    chk("arst_cen", count_en, 0);
    chk("arst_pos", pos, 0);
    chk("arst_pulse", {shift_left, shift_right}, 0);
    chk("arst_resp", resp_valid, 0);
    chk("arst_ready", req_ready, 0);
    tick();
    tick();
    rst = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      saw |= resp_valid;
    end
    chk("dropped_no_resp", saw, 0);
    serve('{0, 1, 0, 1});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
